// File: rtl/video_pkg.sv
// Shared raster timing defaults, pixel width and scan pipeline bundle
// for the frame store and its look-up table stage.
package video_pkg;

    localparam int PIXEL_W = 8;

    localparam int H_ACTIVE_DEF = 320;
    localparam int H_FP_DEF     = 8;
    localparam int H_SYNC_DEF   = 32;
    localparam int H_BP_DEF     = 40;
    localparam int V_ACTIVE_DEF = 200;
    localparam int V_FP_DEF     = 2;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 58;

    typedef struct packed {
        logic de;
        logic hsync_;
        logic vsync_;
        logic frame_start;
    } scan_ctl_t;

    localparam scan_ctl_t CTL_RESET = '{
        de: 1'b0, hsync_: 1'b1, vsync_: 1'b1, frame_start: 1'b0
    };

    function automatic int h_tot(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_tot(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // True while pos sits inside the sync pulse window
    function automatic logic sync_on(int pos, int active, int fp, int sync);
        return (pos >= active + fp) && (pos < active + fp + sync);
    endfunction

endpackage

// File: rtl/video_memory_scan_if.sv
// Processor-side write port of the frame store.
interface video_memory_scan_if #(
    parameter int DATA_W = video_pkg::PIXEL_W,
    parameter int ADDR_W = 16
);
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic              s_;
    logic              mw_;

    modport master (output d, a, s_, mw_);
    modport slave  (input  d, a, s_, mw_);
endinterface

// File: rtl/raster_timing.sv
// Horizontal/vertical raster counters with sync, active and frame decode.
module raster_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic clock,
    input  logic reset_,
    output logic active,
    output logic hsync_,
    output logic vsync_,
    output logic origin,
    output logic frame_end,
    output logic pixel_end
);

    localparam int H_TOT = h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_end;
    logic          v_end;

    assign h_end = (h == HW'(H_TOT - 1));
    assign v_end = (v == VW'(V_TOT - 1));

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            h <= '0;
            v <= '0;
        end else if (h_end) begin
            h <= '0;
            v <= v_end ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    assign active    = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    assign hsync_    = !sync_on(int'(h), H_ACTIVE, H_FP, H_SYNC);
    assign vsync_    = !sync_on(int'(v), V_ACTIVE, V_FP, V_SYNC);
    assign origin    = (h == '0) && (v == '0);
    assign frame_end = h_end && v_end;
    assign pixel_end = (int'(h) == H_ACTIVE - 1)
                    && (int'(v) == V_ACTIVE - 1);

endmodule

// File: rtl/video_memory_scan.sv
// Dual-port frame store scanned in raster order, with optional
// double buffering that flips the shown page only between frames.
module video_memory_scan
    import video_pkg::*;
#(
    parameter int DATA_W     = PIXEL_W,
    parameter int ADDR_W     = 16,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int DOUBLE_BUF = 0
) (
    input  logic              clock,
    input  logic              reset_,
    video_memory_scan_if.slave bus,
    input  logic              page_req,
    output logic [DATA_W-1:0] q,
    output logic              de,
    output logic              hsync_,
    output logic              vsync_,
    output logic              frame_start,
    output logic              page_cur
);

    localparam logic DB     = (DOUBLE_BUF != 0);
    localparam int   PAGE_W = DB ? ADDR_W - 1 : ADDR_W;
    localparam int   DEPTH  = 2 ** ADDR_W;

    if (H_ACTIVE * V_ACTIVE > 2 ** PAGE_W) begin : g_size_check
        $error("active frame does not fit in one page");
    end

    logic              active;
    logic              hs0;
    logic              vs0;
    logic              origin;
    logic              frame_end;
    logic              pixel_end;

    raster_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock     (clock),
        .reset_    (reset_),
        .active    (active),
        .hsync_    (hs0),
        .vsync_    (vs0),
        .origin    (origin),
        .frame_end (frame_end),
        .pixel_end (pixel_end)
    );

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic              page_next;

    // The page and base are loaded together so the new frame starts
    // reading from the new page at its very first pixel.
    always_comb begin
        page_next = page_cur;
        addr_next = addr;
        if (frame_end) begin
            page_next = page_req & DB;
            addr_next = DB ? (ADDR_W'(page_next) << (ADDR_W - 1)) : '0;
        end else if (active && !pixel_end) begin
            addr_next = addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            addr     <= '0;
            page_cur <= 1'b0;
        end else begin
            addr     <= addr_next;
            page_cur <= page_next;
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd;

    always_ff @(posedge clock) begin
        if (!bus.s_ && !bus.mw_) begin
            mem[bus.a] <= bus.d;
        end
    end

    // Same-edge write lands after this read, so collisions see old data
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            rd <= '0;
        end else begin
            rd <= mem[addr];
        end
    end

    scan_ctl_t s0;
    scan_ctl_t s1;
    scan_ctl_t s2;

    assign s0 = '{de: active, hsync_: hs0, vsync_: vs0, frame_start: origin};

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            s1 <= CTL_RESET;
            s2 <= CTL_RESET;
            q  <= '0;
        end else begin
            s1 <= s0;
            s2 <= s1;
            q  <= s1.de ? rd : '0;
        end
    end

    assign de          = s2.de;
    assign hsync_      = s2.hsync_;
    assign vsync_      = s2.vsync_;
    assign frame_start = s2.frame_start;

endmodule

// File: tb/tb_video_memory_scan.sv
// Scoreboard bench: one single-page and one double-buffered frame store
// on a shrunken raster, compared cycle by cycle against a position model.
module tb_video_memory_scan;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int H_TOT = HA + HFP + HS + HBP;
    localparam int V_TOT = VA + VFP + VS + VBP;
    localparam int PAGE  = 128;

    logic       clock;
    logic       reset_;
    logic       page_req;
    logic [7:0] q0, q1;
    logic       de0, de1, hs0, hs1, vs0, vs1, fs0, fs1, pg0, pg1;

    video_memory_scan_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
    video_memory_scan_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();

    video_memory_scan #(
        .DATA_W(8), .ADDR_W(8),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .DOUBLE_BUF(0)
    ) dut0 (
        .clock(clock), .reset_(reset_), .bus(bus0), .page_req(page_req),
        .q(q0), .de(de0), .hsync_(hs0), .vsync_(vs0),
        .frame_start(fs0), .page_cur(pg0)
    );

    video_memory_scan #(
        .DATA_W(8), .ADDR_W(8),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .DOUBLE_BUF(1)
    ) dut1 (
        .clock(clock), .reset_(reset_), .bus(bus1), .page_req(page_req),
        .q(q1), .de(de1), .hsync_(hs1), .vsync_(vs1),
        .frame_start(fs1), .page_cur(pg1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];
    logic [11:0] sb0 [$];
    logic [11:0] sb1 [$];
    int   t;
    logic page1, nxt1;
    logic running   = 1'b0;
    logic pre_reset = 1'b1;

    int   cyc        = 0;
    int   de_run     = 0;
    int   hs_low     = 0;
    int   vs_low     = 0;
    int   de_fall_at = -1;
    int   hs_fall_at = -1;
    int   fs_at      = -1;
    int   since0     = -1;
    int   f0         = 0;
    int   f1         = 0;
    logic de_p       = 1'b0;
    logic hs_p       = 1'b1;
    logic vs_p       = 1'b1;

    function automatic logic [7:0] v0(int i);
        logic [7:0] r;
        r = 8'(i) ^ 8'hC3;
        if (i == 0) r = 8'h11;
        if (i == 1) r = 8'h22;
        if (i == 5) r = 8'h55;
        if (i == HA) r = 8'h33;
        return r;
    endfunction

    function automatic logic [7:0] v1(int i);
        return (i >= PAGE) ? 8'h77 : 8'(i + 'h40);
    endfunction

    task automatic wr0(int a, logic [7:0] d);
        bus0.a = 8'(a); bus0.d = d; bus0.s_ = 1'b0; bus0.mw_ = 1'b0;
        mem0[a] = d;
    endtask

    task automatic wr1(int a, logic [7:0] d);
        bus1.a = 8'(a); bus1.d = d; bus1.s_ = 1'b0; bus1.mw_ = 1'b0;
        mem1[a] = d;
    endtask

    task automatic sb_cycle();
        int h, v, idx;
        logic act, hs, vs, fs;
        logic [7:0] p0, p1;
        if (sb0.size() == 2) begin
            check("sb0", 32'({q0, de0, hs0, vs0, fs0}), 32'(sb0.pop_front()));
            check("sb1", 32'({q1, de1, hs1, vs1, fs1}), 32'(sb1.pop_front()));
        end
        h = t % H_TOT;
        v = (t / H_TOT) % V_TOT;
        if (h == 0 && v == 0 && t > 0) page1 = nxt1;
        act = (h < HA) && (v < VA);
        idx = h + HA * v;
        p0 = act ? mem0[idx] : 8'h00;
        p1 = act ? mem1[(page1 ? PAGE : 0) + idx] : 8'h00;
        hs = !(h >= HA + HFP && h < HA + HFP + HS);
        vs = !(v >= VA + VFP && v < VA + VFP + VS);
        fs = (h == 0 && v == 0);
        check("page_cur0", 32'(pg0), 32'd0);
        check("page_cur1", 32'(pg1), 32'(page1));
        if (h == H_TOT - 1 && v == V_TOT - 1) nxt1 = page_req;
        sb0.push_back({p0, act, hs, vs, fs});
        sb1.push_back({p1, act, hs, vs, fs});
        t++;
    endtask

    task automatic monitor();
        if (de0) de_run++;
        if (de_p && !de0) begin
            check("de_len", 32'(de_run), 32'(HA));
            de_run = 0;
            de_fall_at = cyc;
        end
        if (!hs0) hs_low++;
        if (hs_p && !hs0) begin
            if (de_fall_at >= 0 && cyc - de_fall_at < H_TOT)
                check("hs_delay", 32'(cyc - de_fall_at), 32'(HFP));
            if (hs_fall_at >= 0)
                check("line_per", 32'(cyc - hs_fall_at), 32'(H_TOT));
            hs_fall_at = cyc;
        end
        if (!hs_p && hs0) begin
            check("hs_len", 32'(hs_low), 32'(HS));
            hs_low = 0;
        end
        if (!vs0) vs_low++;
        if (!vs_p && vs0) begin
            check("vs_len", 32'(vs_low), 32'(VS * H_TOT));
            vs_low = 0;
        end
        if (fs0) begin
            if (fs_at >= 0)
                check("frame_per", 32'(cyc - fs_at), 32'(H_TOT * V_TOT));
            fs_at = cyc;
            since0 = 0;
            f0++;
            check("fs_q", 32'(q0), 32'h11);
            check("fs_de", 32'(de0), 32'd1);
        end else if (since0 >= 0) begin
            since0++;
        end
        if (since0 == 1) check("px1", 32'(q0), 32'h22);
        if (since0 == 5) check("collide", 32'(q0), (f0 == 1) ? 32'h55 : 32'hAA);
        if (since0 == H_TOT) check("line1", 32'(q0), 32'h33);
        if (fs1) begin
            f1++;
            if (pre_reset) begin
                check("flip_q", 32'(q1), (f1 >= 2) ? 32'h77 : 32'h40);
                check("flip_page", 32'(pg1), (f1 >= 2) ? 32'd1 : 32'd0);
            end
        end
        de_p = de0;
        hs_p = hs0;
        vs_p = vs0;
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        if (running) begin
            monitor();
            sb_cycle();
        end
        bus0.s_ = 1'b1; bus0.mw_ = 1'b1;
        bus1.s_ = 1'b1; bus1.mw_ = 1'b1;
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_0"}, 32'({q0, de0, hs0, vs0, fs0, pg0}), 32'({8'h00, 5'b01100}));
        check({tag, "_1"}, 32'({q1, de1, hs1, vs1, fs1, pg1}), 32'({8'h00, 5'b01100}));
    endtask

    task automatic enter_reset();
        reset_ = 1'b0;
        running = 1'b0;
        #1;
        sb0.delete();
        sb1.delete();
        de_run = 0; hs_low = 0; vs_low = 0;
        de_fall_at = -1; hs_fall_at = -1; fs_at = -1; since0 = -1;
        de_p = 1'b0; hs_p = 1'b1; vs_p = 1'b1;
        reset_checks("rst_mid");
    endtask

    task automatic release_reset();
        reset_ = 1'b1;
        running = 1'b1;
        t = 0;
        page1 = 1'b0;
        nxt1 = 1'b0;
        sb_cycle();
    endtask

    initial begin
        reset_ = 1'b0;
        page_req = 1'b0;
        bus0.a = '0; bus0.d = '0; bus0.s_ = 1'b1; bus0.mw_ = 1'b1;
        bus1.a = '0; bus1.d = '0; bus1.s_ = 1'b1; bus1.mw_ = 1'b1;
        repeat (3) step();
        reset_checks("rst_hold");
        for (int i = 0; i < 256; i++) begin
            step();
            wr0(i, v0(i));
            wr1(i, v1(i));
        end
        step();
        reset_checks("rst_fill");
        release_reset();
        for (int k = 1; k <= 3 * H_TOT * V_TOT + 2 * H_TOT + 5; k++) begin
            step();
            if (k == 5) wr0(5, 8'hAA);
            if (k == 40) page_req = 1'b1;
        end
        enter_reset();
        pre_reset = 1'b0;
        repeat (2) step();
        reset_checks("rst_held");
        release_reset();
        repeat (2 * H_TOT * V_TOT + 4) step();
        check("frames_seen", 32'(f0 >= 5), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
